// File: rtl/fortune_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fortune_pkg
// Description : Shared types and constants for the fortune reveal sequencer.
//               Holds the sequencer state encoding and the character, pattern
//               and address widths used by the control block and its
//               sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package fortune_pkg;

    localparam int MSG_LEN = 4;               // characters per fortune
    localparam int CHAR_W  = 7;               // character code width
    localparam int PAT_W   = 6;               // fortune selector width
    localparam int ADDR_W  = PAT_W + 2;       // {pattern, idx}
    localparam int IDX_W   = $clog2(MSG_LEN); // character index width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SHOW = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : fortune_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Rising-edge detector. A single flop holds the previous value
//               of d; pulse is high for one cycle when d is high and was low
//               in the previous cycle.
// Ports       : clk    - system clock
//               resetn - asynchronous active-low reset
//               d      - level input
//               pulse  - one-cycle rising-edge pulse (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic pulse
);

    logic r_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_d <= 1'b0;
        end else begin
            r_d <= d;
        end
    end

    assign pulse = d & ~r_d;

endmodule : rise_detect
`default_nettype wire

// File: rtl/fortune_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fortune_reveal_ctrl
// Description : Reads a four-character fortune from an external synchronous
//               message memory and reveals it one character at a time, each
//               character held for TICK_DIV cycles.
// Ports       : clk        - system clock
//               resetn     - asynchronous active-low reset
//               go         - start level; only its rising edge acts
//               cancel     - synchronous abort
//               pattern    - fortune selector, latched on the accepted start
//               mem_rd     - memory read strobe
//               mem_addr   - memory address {latched pattern, idx}
//               mem_q      - memory data, valid the cycle after mem_rd
//               char_out   - character currently revealed
//               char_valid - char_out holds a real character
//               idx        - index of the current character
//               busy       - sequence in progress
//               done       - one-cycle pulse after the last character
// Revision    : 1.0 - initial release
// ============================================================================
module fortune_reveal_ctrl
    import fortune_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic              cancel,
    input  logic [PAT_W-1:0]  pattern,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [CHAR_W-1:0] mem_q,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    output logic [IDX_W-1:0]  idx,
    output logic              busy,
    output logic              done
);

    localparam int                     c_TIMER_W   = $clog2(TICK_DIV + 1);
    localparam logic [c_TIMER_W-1:0]   c_TIMER_END = c_TIMER_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]       c_IDX_LAST  = IDX_W'(MSG_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_go_rise;
    logic                  w_timer_end;
    logic [c_TIMER_W-1:0]  r_timer;
    logic [PAT_W-1:0]      r_pattern;
    logic [IDX_W-1:0]      r_idx;
    logic [CHAR_W-1:0]     r_char;
    logic                  r_char_valid;

    // The edge register tracks go in every state, so a level held high
    // across DONE->IDLE never looks like a new edge.
    rise_detect u_go_edge (
        .clk    (clk),
        .resetn (resetn),
        .d      (go),
        .pulse  (w_go_rise)
    );

    assign w_timer_end = (r_state == SHOW) && (r_timer == c_TIMER_END);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; cancel overrides everything including a go edge
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (cancel) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_go_rise) w_state_nxt = READ;
                READ:    w_state_nxt = WAIT;
                WAIT:    w_state_nxt = SHOW;
                SHOW:    if (w_timer_end) w_state_nxt = (r_idx == c_IDX_LAST) ? DONE : READ;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            READ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
            end
            WAIT:    busy = 1'b1;
            SHOW:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pattern latch, character index, display register, timer.
    // char_out is only overwritten at the end of WAIT so the display keeps
    // the previous character while the next one is being fetched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pattern    <= '0;
            r_idx        <= '0;
            r_char       <= '0;
            r_char_valid <= 1'b0;
            r_timer      <= '0;
        end else if (cancel) begin
            r_idx        <= '0;
            r_char_valid <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go_rise) begin
                        r_pattern    <= pattern;
                        r_idx        <= '0;
                        r_char_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    r_char       <= mem_q;
                    r_char_valid <= 1'b1;
                    r_timer      <= '0;
                end
                SHOW: begin
                    if (w_timer_end) begin
                        r_timer <= '0;
                        // idx stays at the last character after DONE; it
                        // only returns to 0 on the next start or a cancel.
                        if (r_idx != c_IDX_LAST) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = {r_pattern, r_idx};
    assign char_out   = r_char;
    assign char_valid = r_char_valid;
    assign idx        = r_idx;

endmodule : fortune_reveal_ctrl
`default_nettype wire

// File: tb/tb_fortune_reveal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fortune_reveal_ctrl
// Description : Self-checking bench for fortune_reveal_ctrl with TICK_DIV=4
//               and a one-cycle-latency memory whose content is
//               addr[6:0] ^ 7'h55.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fortune_reveal_ctrl;

    localparam int c_TICK = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       cancel = 1'b0;
    logic [5:0] pattern = 6'h00;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [6:0] mem_q = 7'h00;
    logic [6:0] char_out;
    logic       char_valid;
    logic [1:0] idx;
    logic       busy;
    logic       done;

    fortune_reveal_ctrl #(.TICK_DIV(c_TICK)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .cancel     (cancel),
        .pattern    (pattern),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .char_out   (char_out),
        .char_valid (char_valid),
        .idx        (idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Message memory model
    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem_addr[6:0] ^ 7'h55;
    end

    // Expected outputs of one sequence with pattern 6'h2A, by cycle number
    // (cycle 0 = go rises). chk_co=0 where char_out still shows whatever the
    // previous sequence left behind.
    typedef struct {
        int         cyc;
        logic       rd;
        logic [7:0] addr;
        logic       bsy;
        logic       dn;
        logic       cv;
        logic       chk_co;
        logic [6:0] co;
        logic [1:0] ix;
    } vec_t;

    vec_t       tbl [14];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] addr_log [$];
    logic [7:0] exp_addr [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int c, input int i);
        logic [20:0] act;
        logic [20:0] exp;
        act = {mem_rd, mem_addr, busy, done, char_valid,
               (tbl[i].chk_co ? char_out : 7'h00), idx};
        exp = {tbl[i].rd, tbl[i].addr, tbl[i].bsy, tbl[i].dn, tbl[i].cv,
               (tbl[i].chk_co ? tbl[i].co : 7'h00), tbl[i].ix};
        chk($sformatf("vec_c%0d {rd,addr,busy,done,cv,co,idx}", c), 32'(act), 32'(exp));
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic idle(input int n, output int rd_n, output int busy_n);
        rd_n = 0;
        busy_n = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (mem_rd) rd_n++;
            if (busy) busy_n++;
            @(posedge clk);
            #1;
        end
    endtask

    // One sequence: go rises in cycle 0 with pattern 2A and stays high while
    // c < go_until; an extra go edge with pattern 15 at go2; cancel at cxl.
    task automatic run(input int ncyc, input int go_until, input int go2,
                       input int cxl, input int tbl_upto,
                       output int rd_n, output int done_n, output int done_at);
        rd_n = 0;
        done_n = 0;
        done_at = -1;
        addr_log.delete();
        for (int c = 0; c < ncyc; c++) begin
            go      = (c < go_until) || (c == go2);
            pattern = (c == go2) ? 6'h15 : 6'h2A;
            cancel  = (c == cxl);
            @(negedge clk);
            for (int i = 0; i < 14; i++) begin
                if (tbl[i].cyc == c && c <= tbl_upto) chk_vec(c, i);
            end
            if (cxl >= 0 && c == cxl + 1) begin
                chk("cancel_busy", 32'(busy), 32'd0);
                chk("cancel_char_valid", 32'(char_valid), 32'd0);
                chk("cancel_idx", 32'(idx), 32'd0);
            end
            if (mem_rd) begin
                rd_n++;
                addr_log.push_back(mem_addr);
            end
            if (done) begin
                done_n++;
                done_at = c;
            end
            @(posedge clk);
            #1;
        end
        go = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic chk_addrs(input string tag);
        chk({tag, "_addr_count"}, 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(exp_addr[i]));
        end
    endtask

    initial begin
        int rd_n, done_n, done_at, busy_n;

        tbl[0]  = '{1,  1'b1, 8'hA8, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0};
        tbl[1]  = '{2,  1'b0, 8'hA8, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 2'd0};
        tbl[2]  = '{3,  1'b0, 8'hA8, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7D, 2'd0};
        tbl[3]  = '{6,  1'b0, 8'hA8, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7D, 2'd0};
        tbl[4]  = '{7,  1'b1, 8'hA9, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7D, 2'd1};
        tbl[5]  = '{8,  1'b0, 8'hA9, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7D, 2'd1};
        tbl[6]  = '{9,  1'b0, 8'hA9, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7C, 2'd1};
        tbl[7]  = '{13, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7C, 2'd2};
        tbl[8]  = '{15, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7F, 2'd2};
        tbl[9]  = '{19, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7F, 2'd3};
        tbl[10] = '{21, 1'b0, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7E, 2'd3};
        tbl[11] = '{24, 1'b0, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 7'h7E, 2'd3};
        tbl[12] = '{25, 1'b0, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b1, 7'h7E, 2'd3};
        tbl[13] = '{26, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7E, 2'd3};
        exp_addr[0] = 8'hA8;
        exp_addr[1] = 8'hA9;
        exp_addr[2] = 8'hAA;
        exp_addr[3] = 8'hAB;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({mem_rd, mem_addr, char_out, char_valid, idx, busy, done}), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // go held low
        idle(20, rd_n, busy_n);
        chk("idle_mem_rd_count", 32'(rd_n), 32'd0);
        chk("idle_busy_count", 32'(busy_n), 32'd0);

        // Single go pulse
        run(30, 1, -1, -1, 26, rd_n, done_n, done_at);
        chk("pulse_rd_count", 32'(rd_n), 32'd4);
        chk("pulse_done_count", 32'(done_n), 32'd1);
        chk("pulse_done_cycle", 32'(done_at), 32'd25);
        chk_addrs("pulse");
        idle(2, rd_n, busy_n);

        // go held high for 60 cycles: one sequence only
        run(60, 60, -1, -1, 26, rd_n, done_n, done_at);
        chk("held_rd_count", 32'(rd_n), 32'd4);
        chk("held_done_count", 32'(done_n), 32'd1);
        idle(2, rd_n, busy_n);

        // Second go edge at cycle 10 with another pattern is ignored
        run(30, 1, 10, -1, 26, rd_n, done_n, done_at);
        chk("go2_done_count", 32'(done_n), 32'd1);
        chk_addrs("go2");
        idle(2, rd_n, busy_n);

        // Cancel in cycle 14, then a clean restart
        run(30, 1, -1, 14, 13, rd_n, done_n, done_at);
        chk("cancel_rd_count", 32'(rd_n), 32'd3);
        chk("cancel_done_count", 32'(done_n), 32'd0);
        idle(2, rd_n, busy_n);
        run(30, 1, -1, -1, 26, rd_n, done_n, done_at);
        chk("restart_done_cycle", 32'(done_at), 32'd25);
        chk_addrs("restart");
        idle(2, rd_n, busy_n);

        // Asynchronous reset mid-cycle in cycle 9
        for (int c = 0; c < 9; c++) begin
            go = (c == 0);
            pattern = 6'h2A;
            @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({mem_rd, mem_addr, char_out, char_valid, idx, busy, done}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(10, rd_n, busy_n);
        chk("post_reset_rd_count", 32'(rd_n), 32'd0);
        chk("post_reset_busy_count", 32'(busy_n), 32'd0);
        run(30, 1, -1, -1, 26, rd_n, done_n, done_at);
        chk("post_reset_done_count", 32'(done_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fortune_reveal_ctrl
`default_nettype wire
